// File: rtl/fp32_coproc_pkg.sv
// Shared constants and types for the FP32 coprocessor PCPI bridge.
package fp32_coproc_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;
    localparam logic [6:0] FUNCT7_DOT2    = 7'b0000001;

    localparam logic [2:0] F3_LOADAB = 3'b000;
    localparam logic [2:0] F3_RUN    = 3'b001;
    localparam logic [2:0] F3_STAT   = 3'b010;

    localparam logic [XLEN-1:0] FP32_QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_RES  = 3'd3,
        ST_WAIT_DROP = 3'd4,
        ST_RESPOND   = 3'd5
    } state_t;

    // R-type instruction word layout
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } rv_insn_t;

endpackage

// File: rtl/fp32_dot2_pcpi_bridge.sv
// PCPI bridge feeding the FP32 a*b+c*d stage: LOADAB latches a/b, RUN latches c/d and launches.
// Optional watchdog and STAT instruction enabled by defining DOT2_TIMEOUT_EN.
module fp32_dot2_pcpi_bridge
    import fp32_coproc_pkg::*;
#(
    parameter logic [6:0]  OPCODE         = OPCODE_CUSTOM0,
    parameter logic [6:0]  FUNCT7         = FUNCT7_DOT2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pcpi_valid,
    input  logic [XLEN-1:0] pcpi_insn,
    input  logic [XLEN-1:0] pcpi_rs1,
    input  logic [XLEN-1:0] pcpi_rs2,
    output logic            pcpi_wr,
    output logic [XLEN-1:0] pcpi_rd,
    output logic            pcpi_wait,
    output logic            pcpi_ready,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] op_c,
    output logic [XLEN-1:0] op_d,
    output logic            op1_input_STB,
    input  logic            op1_BUSY,
    input  logic [XLEN-1:0] op1_result,
    input  logic            op1_output_STB,
    output logic            output_module_BUSY
);

    state_t          state, state_nxt;
    rv_insn_t        insn_c;
    logic            match_c;
    logic            wr_nxt, wait_nxt, ready_nxt, stb_nxt, omb_nxt;
    logic [XLEN-1:0] rd_nxt, a_nxt, b_nxt, c_nxt, d_nxt;
    logic            unused_insn_bits;

    assign insn_c  = rv_insn_t'(pcpi_insn);
    assign match_c = pcpi_valid && (insn_c.opcode == OPCODE) && (insn_c.funct7 == FUNCT7);
    assign unused_insn_bits = ^{insn_c.rs2, insn_c.rs1, insn_c.rd};

`ifdef DOT2_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             flag, flag_nxt;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

    // Next-state and next-output computation
    always_comb begin
        state_nxt = state;
        wr_nxt    = pcpi_wr;
        rd_nxt    = pcpi_rd;
        wait_nxt  = pcpi_wait;
        ready_nxt = pcpi_ready;
        a_nxt     = op_a;
        b_nxt     = op_b;
        c_nxt     = op_c;
        d_nxt     = op_d;
        stb_nxt   = op1_input_STB;
        omb_nxt   = output_module_BUSY;
`ifdef DOT2_TIMEOUT_EN
        cnt_nxt   = cnt;
        flag_nxt  = flag;
`endif
        case (state)
            ST_IDLE: begin
                wr_nxt    = 1'b0;
                ready_nxt = 1'b0;
                if (match_c) begin
                    case (insn_c.funct3)
                        F3_LOADAB: begin
                            a_nxt     = pcpi_rs1;
                            b_nxt     = pcpi_rs2;
                            ready_nxt = 1'b1;
                            state_nxt = ST_RESPOND;
                        end
                        F3_RUN: begin
                            c_nxt     = pcpi_rs1;
                            d_nxt     = pcpi_rs2;
                            wait_nxt  = 1'b1;
                            state_nxt = ST_ISSUE;
`ifdef DOT2_TIMEOUT_EN
                            cnt_nxt   = '0;
`endif
                        end
`ifdef DOT2_TIMEOUT_EN
                        F3_STAT: begin
                            rd_nxt    = {31'b0, flag};
                            wr_nxt    = 1'b1;
                            ready_nxt = 1'b1;
                            flag_nxt  = 1'b0;
                            state_nxt = ST_RESPOND;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            ST_ISSUE: begin
                if (!op1_BUSY) begin
                    stb_nxt   = 1'b1;
                    state_nxt = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (op1_BUSY) begin
                    stb_nxt   = 1'b0;
                    omb_nxt   = 1'b0;
                    state_nxt = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                if (op1_output_STB) begin
                    rd_nxt    = op1_result;
                    state_nxt = ST_WAIT_DROP;
                end
            end
            // Stay not-busy until the stage releases its strobe, otherwise it stalls
            ST_WAIT_DROP: begin
                if (!op1_output_STB) begin
                    omb_nxt   = 1'b1;
                    wr_nxt    = 1'b1;
                    ready_nxt = 1'b1;
                    state_nxt = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                wr_nxt    = 1'b0;
                ready_nxt = 1'b0;
                wait_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

`ifdef DOT2_TIMEOUT_EN
        // Watchdog: abandon the stage and return a quiet NaN
        if (state == ST_ISSUE || state == ST_WAIT_ACK || state == ST_WAIT_RES) begin
            if (cnt == CNT_LAST) begin
                stb_nxt   = 1'b0;
                omb_nxt   = 1'b1;
                rd_nxt    = FP32_QNAN;
                wr_nxt    = 1'b1;
                ready_nxt = 1'b1;
                flag_nxt  = 1'b1;
                state_nxt = ST_RESPOND;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state              <= ST_IDLE;
            pcpi_wr            <= 1'b0;
            pcpi_rd            <= '0;
            pcpi_wait          <= 1'b0;
            pcpi_ready         <= 1'b0;
            op_a               <= '0;
            op_b               <= '0;
            op_c               <= '0;
            op_d               <= '0;
            op1_input_STB      <= 1'b0;
            output_module_BUSY <= 1'b1;
`ifdef DOT2_TIMEOUT_EN
            cnt                <= '0;
            flag               <= 1'b0;
`endif
        end else begin
            state              <= state_nxt;
            pcpi_wr            <= wr_nxt;
            pcpi_rd            <= rd_nxt;
            pcpi_wait          <= wait_nxt;
            pcpi_ready         <= ready_nxt;
            op_a               <= a_nxt;
            op_b               <= b_nxt;
            op_c               <= c_nxt;
            op_d               <= d_nxt;
            op1_input_STB      <= stb_nxt;
            output_module_BUSY <= omb_nxt;
`ifdef DOT2_TIMEOUT_EN
            cnt                <= cnt_nxt;
            flag               <= flag_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_fp32_dot2_pcpi_bridge.sv
// Scoreboard bench for fp32_dot2_pcpi_bridge with a behavioural dot-product stage.
module tb_fp32_dot2_pcpi_bridge;
    import fp32_coproc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pcpi_valid = 1'b0;
    logic [31:0] pcpi_insn = '0, pcpi_rs1 = '0, pcpi_rs2 = '0;
    logic        pcpi_wr, pcpi_wait, pcpi_ready;
    logic [31:0] pcpi_rd, op_a, op_b, op_c, op_d;
    logic        op1_input_STB, output_module_BUSY;
    logic        op1_BUSY = 1'b0, op1_output_STB = 1'b0;
    logic [31:0] op1_result = '0;

    always #5 clk = ~clk;

    fp32_dot2_pcpi_bridge dut (
        .clk(clk), .rst(rst),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
        .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
        .op1_input_STB(op1_input_STB), .op1_BUSY(op1_BUSY), .op1_result(op1_result),
        .op1_output_STB(op1_output_STB), .output_module_BUSY(output_module_BUSY)
    );

    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        bit          wr;
        logic [31:0] rd;
        string       name;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state: operands the core has loaded
    logic [31:0] m_a = '0, m_b = '0;

    int st_lat = 2, st_hold = 1, busy_hold = 0;

    task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    endtask

    function automatic real f2r(input logic [31:0] f);
        int e;
        logic [63:0] d;
        if (f[30:0] == 31'd0) return 0.0;
        e = int'(f[30:23]) - 127 + 1023;
        d = {f[31], 11'(e), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        int e;
        logic [63:0] d;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], 8'(e), d[51:29]};
    endfunction

    function automatic logic [31:0] dot_ref(input logic [31:0] a, b, c, d);
        return r2f(f2r(a) * f2r(b) + f2r(c) * f2r(d));
    endfunction

    function automatic logic [31:0] rand_val();
        int k;
        k = int'($urandom_range(32, 0)) - 16;
        return r2f(real'(k) / 2.0);
    endfunction

    // Behavioural dot-product stage: accepts a strobe when idle, replies after st_lat, holds result st_hold cycles
    initial begin : stage
        int sst, scnt;
        logic [31:0] sres;
        sst = 0; scnt = 0; sres = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                sst = 0; op1_BUSY = 1'b0; op1_output_STB = 1'b0; busy_hold = 0;
            end else begin
                case (sst)
                    0: if (op1_input_STB) begin
                        chk("stb_only_when_stage_idle", !op1_BUSY, 32'(op1_BUSY), 32'd0);
                        sres = dot_ref(op_a, op_b, op_c, op_d);
                        op1_BUSY = 1'b1; scnt = st_lat; sst = 1;
                    end else if (busy_hold > 0) begin
                        op1_BUSY = 1'b1; busy_hold--;
                    end else begin
                        op1_BUSY = 1'b0;
                    end
                    1: if (scnt == 0) begin
                        op1_output_STB = 1'b1; op1_result = sres; scnt = st_hold - 1; sst = 2;
                    end else scnt--;
                    default: if (scnt == 0) begin
                        op1_output_STB = 1'b0; op1_BUSY = 1'b0; sst = 0;
                    end else scnt--;
                endcase
            end
        end
    end

    // Monitor: pop expectations on every ready pulse and police the result handshake
    initial begin : monitor
        bit prev_ready, prev_ostb, pend_fall;
        exp_t e;
        prev_ready = 0; prev_ostb = 0; pend_fall = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_ready = 0; prev_ostb = 0; pend_fall = 0;
            end else begin
                if (pcpi_ready) begin
                    chk("ready_one_cycle", !prev_ready, 32'(prev_ready), 32'd0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ready", 1'b0, 32'(pcpi_ready), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk({e.name, "_wr"}, pcpi_wr == e.wr, 32'(pcpi_wr), 32'(e.wr));
                        if (e.wr) chk({e.name, "_rd"}, pcpi_rd == e.rd, pcpi_rd, e.rd);
                    end
                end
                if (pend_fall) begin
                    chk("ready_after_stb_fall", pcpi_ready && output_module_BUSY,
                        {30'd0, pcpi_ready, output_module_BUSY}, 32'd3);
                    pend_fall = 0;
                end
                if (op1_output_STB) begin
                    chk("omb_low_while_stb", !output_module_BUSY, 32'(output_module_BUSY), 32'd0);
                end else if (prev_ostb) begin
                    chk("omb_low_at_stb_fall", !output_module_BUSY && !pcpi_ready,
                        {30'd0, pcpi_ready, output_module_BUSY}, 32'd0);
                    pend_fall = 1;
                end
                prev_ready = pcpi_ready;
                prev_ostb  = op1_output_STB;
            end
        end
    end

    task automatic issue(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc,
                         input logic [31:0] r1, input logic [31:0] r2, input bit drop_early,
                         input int max_cyc, output bit got, output int cyc);
        bit is_run;
        is_run = (f7 == FUNCT7_DOT2) && (opc == OPCODE_CUSTOM0) && (f3 == F3_RUN);
        @(negedge clk);
        pcpi_valid = 1'b1;
        pcpi_insn  = {f7, 5'd2, 5'd1, f3, 5'd3, opc};
        pcpi_rs1   = r1;
        pcpi_rs2   = r2;
        got = 0; cyc = 0;
        while (!got && cyc < max_cyc) begin
            @(posedge clk); @(negedge clk);
            cyc++;
            if (drop_early) pcpi_valid = 1'b0;
            if (pcpi_ready) got = 1;
            else if (is_run) chk("run_wait_high", pcpi_wait, 32'(pcpi_wait), 32'd1);
        end
        pcpi_valid = 1'b0;
    endtask

    task automatic do_loadab(input logic [31:0] r1, input logic [31:0] r2);
        bit got; int cyc;
        exp_t e;
        e.wr = 0; e.rd = '0; e.name = "loadab";
        exp_q.push_back(e);
        m_a = r1; m_b = r2;
        issue(FUNCT7_DOT2, F3_LOADAB, OPCODE_CUSTOM0, r1, r2, 0, 20, got, cyc);
        chk("loadab_latency", got && cyc == 1, 32'(cyc), 32'd1);
        chk("loadab_no_wait", !pcpi_wait, 32'(pcpi_wait), 32'd0);
    endtask

    task automatic do_run(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] exp_rd,
                          input bit drop_early, output int cyc);
        bit got;
        exp_t e;
        e.wr = 1; e.rd = exp_rd; e.name = "run";
        exp_q.push_back(e);
        issue(FUNCT7_DOT2, F3_RUN, OPCODE_CUSTOM0, r1, r2, drop_early, 400, got, cyc);
        chk("run_completes", got, 32'(cyc), 32'd400);
    endtask

    task automatic do_bad(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
        bit got; int cyc;
        issue(f7, f3, opc, $urandom, $urandom, 0, 12, got, cyc);
        chk("unmatched_no_ready", !got, 32'(got), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin : main
        int cyc;
        logic [31:0] r1, r2;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr", pcpi_wr == 0, 32'(pcpi_wr), 32'd0);
        chk("rst_rd", pcpi_rd == 0, pcpi_rd, 32'd0);
        chk("rst_wait_ready", !pcpi_wait && !pcpi_ready, {30'd0, pcpi_wait, pcpi_ready}, 32'd0);
        chk("rst_ops", (op_a | op_b | op_c | op_d) == 0, op_a | op_b | op_c | op_d, 32'd0);
        chk("rst_stb", !op1_input_STB, 32'(op1_input_STB), 32'd0);
        chk("rst_omb", output_module_BUSY, 32'(output_module_BUSY), 32'd1);
        rst = 1'b1;

        // 2*3 + 1.5*4 = 12.0
        do_loadab(32'h4000_0000, 32'h4040_0000);
        do_run(32'h3FC0_0000, 32'h4080_0000, 32'h4140_0000, 0, cyc);
        do_loadab(rand_val(), rand_val());

        // Result strobe held for 5 cycles
        st_hold = 5;
        r1 = rand_val(); r2 = rand_val();
        do_run(r1, r2, dot_ref(m_a, m_b, r1, r2), 0, cyc);
        st_hold = 1;

        // Stage busy for 8 cycles when RUN arrives
        busy_hold = 8; st_lat = 1;
        r1 = rand_val(); r2 = rand_val();
        do_run(r1, r2, dot_ref(m_a, m_b, r1, r2), 0, cyc);
        chk("busy_delays_strobe", cyc >= 13, 32'(cyc), 32'd13);

        // Unmatched encodings must never get a ready
        do_bad(FUNCT7_DOT2, 3'b111, OPCODE_CUSTOM0);
        do_bad(FUNCT7_DOT2, F3_RUN, 7'b0101011);
        do_bad(7'b0000000, F3_LOADAB, OPCODE_CUSTOM0);
`ifndef DOT2_TIMEOUT_EN
        do_bad(FUNCT7_DOT2, F3_STAT, OPCODE_CUSTOM0);
`endif

        // Randomised mix of transactions and stage timings
        for (int i = 0; i < 24; i++) begin
            st_lat  = int'($urandom_range(6, 0));
            st_hold = int'($urandom_range(4, 1));
            r1 = rand_val(); r2 = rand_val();
            case ($urandom_range(3, 0))
                0: do_loadab(r1, r2);
                1: do_run(r1, r2, dot_ref(m_a, m_b, r1, r2), 0, cyc);
                2: do_run(r1, r2, dot_ref(m_a, m_b, r1, r2), 1, cyc);
                default: do_bad(FUNCT7_DOT2, 3'($urandom_range(7, 3)), OPCODE_CUSTOM0);
            endcase
        end

        // Reset asserted while waiting for the stage result
        st_lat = 20; st_hold = 1;
        do_loadab(32'h4000_0000, 32'h4000_0000);
        @(negedge clk);
        pcpi_valid = 1'b1;
        pcpi_insn  = {FUNCT7_DOT2, 5'd2, 5'd1, F3_RUN, 5'd3, OPCODE_CUSTOM0};
        pcpi_rs1   = 32'h4000_0000;
        pcpi_rs2   = 32'h4000_0000;
        cyc = 0;
        do begin
            @(posedge clk); @(negedge clk);
            pcpi_valid = 1'b0;
            cyc++;
        end while (output_module_BUSY && cyc < 30);
        chk("reached_wait_res", !output_module_BUSY, 32'(output_module_BUSY), 32'd0);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("mid_rst_rd", pcpi_rd == 0, pcpi_rd, 32'd0);
        chk("mid_rst_flags", !pcpi_wr && !pcpi_wait && !pcpi_ready && !op1_input_STB,
            {28'd0, pcpi_wr, pcpi_wait, pcpi_ready, op1_input_STB}, 32'd0);
        chk("mid_rst_omb", output_module_BUSY, 32'(output_module_BUSY), 32'd1);
        chk("mid_rst_ops", (op_a | op_b | op_c | op_d) == 0, op_a | op_b | op_c | op_d, 32'd0);
        exp_q.delete();
        m_a = '0; m_b = '0;
        rst = 1'b1;
        st_lat = 2;

        // RUN with no LOADAB after reset: a*b is 0, so 1*1 -> 1.0
        do_run(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 0, cyc);
        do_loadab(32'h3F80_0000, 32'h3F80_0000);
        do_run(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 0, cyc);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size() == 0, 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
